a429_rx: RTL
============

Name: a429_rx

Overview:
- ARINC429 receive path. It is the downstream counterpart of the A429 transmitter and consumes the differential line it drives.
- Synchronises the A/B line, qualifies bit cells and inter-word gaps, and reassembles 32-bit words into the transmitter's FIFO data format.
- Checks odd parity and pushes each complete word into the RX FIFO (write-only interface).
- Sits between the line receiver pins and the RX FIFO, alongside the TX module in the controller top.

Parameters:
- CLOCK_KHZ, 100000, clk_i frequency in kHz.
- Derived constant HB = CLOCK_KHZ*10/1000/2 is the half-bit cycle count at 100 kbps. It is 500 at the default.
- Half-bit time is HB when hi_spd=1 and 8*HB when hi_spd=0.

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  synchronous, active-low reset
- rx_ena  in  1  receive enable
- hi_spd  in  1  1 = 100 kbps, 0 = 12.5 kbps
- rx_10  in  2  line state: 2'b10 = HI, 2'b01 = LO, 2'b00 = NULL, 2'b11 = illegal; asynchronous to clk_i
- rf_wr  out  1  FIFO write strobe, one-cycle pulse
- rf_di  out  32  FIFO write data
- rf_ff  in  1  FIFO full flag
- err_o  out  1  frame error, one-cycle pulse
- ovf_o  out  1  overrun (word dropped because FIFO full), one-cycle pulse

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_i is synchronous and active-low.
- Reset (rst_i=0 at a clk_i edge):
  - rf_wr, err_o, ovf_o = 0; rf_di = 0.
  - Synchroniser = NULL; state = SYNC; all counters cleared.
  - A partial word in progress is discarded without error.
- Synchroniser:
  - 2-FF on both bits of rx_10; all decoding uses the synchronised value L.
  - Speed latch: spd is latched from hi_spd only while in SYNC or IDLE. HBc = spd ? HB : 8*HB.
  - Null counter and active counter each saturate and are sized with calc_cw(16*HB).
- States:
  - SYNC:
    - Counts consecutive L=NULL cycles; any non-NULL restarts the count.
    - When the count reaches 2*HBc, go to IDLE.
  - IDLE:
    - L=HI or LO: go to ACT with b_num=0.
    - L=11: go to SYNC with err_o.
  - ACT:
    - Counts active cycles.
    - Error (err_o, go to SYNC) on any of: L flips polarity without passing through NULL; L=11; active count exceeds 2*HBc.
    - On L=NULL with active count < HBc/2: glitch, err_o, go to SYNC.
    - Otherwise on L=NULL: store bit b[b_num] = (level==HI). If b_num=31 go to WORD; else increment b_num and go to NUL.
  - NUL:
    - L=HI or LO: go to ACT.
    - L=11: err_o, go to SYNC.
    - NULL count > 2*HBc: truncated word, err_o, go to IDLE (gap already satisfied).
  - WORD (one cycle):
    - rf_ff=0: rf_wr=1 with rf_di.
    - rf_ff=1: ovf_o=1, no write.
    - Then go to SYNC, which enforces the inter-word gap.
- rf_di mapping (b[0] is the first bit on the line):
  - rf_di[7-k] = b[k] for k = 0..7
  - rf_di[31:11] = b[28:8]
  - rf_di[9] = b[29]
  - rf_di[10] = b[30]
  - rf_di[8] = parity error = ~^b[31:0] (odd parity expected)
  - rf_di holds its value until the next word.
- Latency: rf_wr is high on the 4th rising edge after the first NULL following bit 31 is applied at rx_10 (2 sync edges + ACT + WORD).
- rx_ena=0: forces SYNC next cycle, discards the partial word, and asserts no err_o.
- Pulse exclusivity: err_o, ovf_o and rf_wr are mutually exclusive in any cycle.
- hi_spd changes mid-word are ignored until the next SYNC/IDLE.

Decomposition:
- Shared include a429_defs:
  - AB_1/AB_0/AB_N line encodings.
  - HB derivation from CLOCK_KHZ.
  - RX state encodings.
  - The bit-order mapping, shared with TX as a pair of functions.
- calc_cw comes from the existing bit_width_utils.
- One sub-module, a429_rx_sync: 2-FF synchroniser plus HI/LO/NULL/illegal decode.

Test Plan:
- Loopback from A429_TX, hi_spd=1, tf_do=32'h12345678 -> exactly one rf_wr, rf_di=32'h12345678, err_o=0, ovf_o=0. Repeat at hi_spd=0 with the same result.
- Bench-driven word with parity bit (32nd bit) inverted, payload 32'h12345678 -> rf_di=32'h12345778 (bit 8 set), rf_wr once.
- 20 valid bits then NULL for 6*HB -> one err_o pulse, no rf_wr. A following valid word 32'hA5A5A4A5 -> rf_di=32'hA5A5A4A5.
- Both of the following -> one err_o each, with the next word after a 2*HB gap decoded correctly:
  - HI pulse of HB/4 mid-word.
  - Direct HI->LO transition.
- rf_ff=1 during WORD -> ovf_o pulse, rf_wr=0. rf_ff=0 for the next word -> normal write.
- Low speed, rst_i=0 for 3 cycles at bit 15 -> all outputs 0. The partial word is never written. The next full word is written correctly.

Source files
------------

// File: rtl/a429_rx_pkg.sv
// Shared ARINC429 definitions: line encodings, half-bit timing, RX states and
// the FIFO-word <-> line-bit-order mapping used by both the TX and RX paths.
package a429_rx_pkg;

    localparam logic [1:0] AB_1 = 2'b10;
    localparam logic [1:0] AB_0 = 2'b01;
    localparam logic [1:0] AB_N = 2'b00;

    typedef enum logic [2:0] {
        RX_SYNC,
        RX_IDLE,
        RX_ACT,
        RX_NUL,
        RX_WORD
    } rx_state_t;

    // Half-bit cycle count at 100 kbps.
    function automatic int hb_of(input int clock_khz);
        return clock_khz * 10 / 1000 / 2;
    endfunction

    function automatic int calc_cw(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

    // Line bits (b[0] first on the wire) to FIFO word; bit 8 flags bad parity.
    function automatic logic [31:0] bits_to_fifo(input logic [31:0] b);
        logic [31:0] d;
        for (int k = 0; k < 8; k++) d[7-k] = b[k];
        d[31:11] = b[28:8];
        d[10]    = b[30];
        d[9]     = b[29];
        d[8]     = ~^b;
        return d;
    endfunction

    // FIFO word to line bits with odd parity generated in bit 31.
    function automatic logic [31:0] fifo_to_bits(input logic [31:0] d);
        logic [31:0] b;
        for (int k = 0; k < 8; k++) b[k] = d[7-k];
        b[28:8] = d[31:11];
        b[29]   = d[9];
        b[30]   = d[10];
        b[31]   = ~^b[30:0];
        return b;
    endfunction

endpackage

// File: rtl/a429_rx_sync.sv
// Two-flop synchroniser for the asynchronous A/B line plus HI/LO/NULL/illegal
// decode of the synchronised state.
module a429_rx_sync
    import a429_rx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] rx_10,
    output logic       is_hi,
    output logic       is_lo,
    output logic       is_null,
    output logic       is_ill
);

    logic [1:0] meta;
    logic [1:0] line;

    // NOTE: flops are written with <= so every stage samples the pre-edge value;
    // blocking assignments here would collapse the two stages into one.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            meta <= AB_N;
            line <= AB_N;
        end else begin
            meta <= rx_10;
            line <= meta;
        end
    end

    assign is_hi   = (line == AB_1);
    assign is_lo   = (line == AB_0);
    assign is_null = (line == AB_N);
    assign is_ill  = (line == 2'b11);

endmodule

// File: rtl/a429_rx.sv
// ARINC429 receiver: qualifies bit cells and gaps on the synchronised line,
// reassembles 32-bit words and writes them into the RX FIFO.
module a429_rx
    import a429_rx_pkg::*;
#(
    parameter int CLOCK_KHZ = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_ena,
    input  logic        hi_spd,
    input  logic [1:0]  rx_10,
    output logic        rf_wr,
    output logic [31:0] rf_di,
    input  logic        rf_ff,
    output logic        err_o,
    output logic        ovf_o
);

    localparam int            HB      = hb_of(CLOCK_KHZ);
    localparam int            CW      = calc_cw(16 * HB);
    localparam logic [CW-1:0] HB_C    = CW'(HB);
    localparam logic [CW-1:0] HB8_C   = CW'(8 * HB);
    localparam logic [CW-1:0] CNT_MAX = '1;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    rx_state_t     state, state_n;
    logic          is_hi, is_lo, is_null, is_ill, is_act;
    logic          spd, level_hi;
    logic [CW-1:0] null_cnt, act_cnt, hbc, two_hbc;
    logic [4:0]    b_num;
    logic [31:0]   bits, word_bits;
    logic          act_err, nul_trunc;

    a429_rx_sync u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .rx_10   (rx_10),
        .is_hi   (is_hi),
        .is_lo   (is_lo),
        .is_null (is_null),
        .is_ill  (is_ill)
    );

    assign is_act    = is_hi | is_lo;
    assign hbc       = spd ? HB_C : HB8_C;
    assign two_hbc   = {hbc[CW-2:0], 1'b0};
    assign word_bits = {level_hi, bits[30:0]};

    // Polarity flip, illegal code, over-long cell, or a pulse too short to be a bit.
    assign act_err   = is_ill
                     | (is_act & (is_hi != level_hi))
                     | (is_act & (act_cnt >= two_hbc))
                     | (is_null & (act_cnt < (hbc >> 1)));
    assign nul_trunc = is_null & (null_cnt >= two_hbc);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= RX_SYNC;
            spd      <= 1'b1;
            level_hi <= 1'b0;
            null_cnt <= '0;
            act_cnt  <= '0;
            b_num    <= '0;
            rf_di    <= '0;
        end else begin
            state <= state_n;
            if (state == RX_SYNC || state == RX_IDLE) spd <= hi_spd;
            if (state_n == RX_ACT && state != RX_ACT) level_hi <= is_hi;

            if (state_n == RX_NUL && state != RX_NUL)
                null_cnt <= CW'(1);
            else if ((state == RX_SYNC && state_n == RX_SYNC && is_null && rx_ena) ||
                     (state == RX_NUL && state_n == RX_NUL))
                null_cnt <= sat_inc(null_cnt);
            else
                null_cnt <= '0;

            if (state_n == RX_ACT && state != RX_ACT) act_cnt <= CW'(1);
            else if (state == RX_ACT && state_n == RX_ACT) act_cnt <= sat_inc(act_cnt);
            else act_cnt <= '0;

            if (state == RX_ACT && state_n == RX_NUL) b_num <= b_num + 5'd1;
            else if (state != RX_ACT && state != RX_NUL) b_num <= '0;

            if (state == RX_ACT && state_n == RX_WORD) rf_di <= bits_to_fifo(word_bits);
        end
    end

    // NOTE: the bit buffer is pure data qualified by b_num, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (state == RX_ACT && (state_n == RX_NUL || state_n == RX_WORD))
            bits[b_num] <= level_hi;
    end

    // NOTE: state_n defaults to the current state so every path assigns it and no latch forms.
    always_comb begin
        state_n = state;
        if (!rx_ena) begin
            state_n = RX_SYNC;
        end else begin
            case (state)
                RX_SYNC: if (is_null && null_cnt >= two_hbc - CW'(1)) state_n = RX_IDLE;
                RX_IDLE: begin
                    if (is_act) state_n = RX_ACT;
                    else if (is_ill) state_n = RX_SYNC;
                end
                RX_ACT: begin
                    if (act_err) state_n = RX_SYNC;
                    else if (is_null) state_n = (b_num == 5'd31) ? RX_WORD : RX_NUL;
                end
                RX_NUL: begin
                    if (is_ill) state_n = RX_SYNC;
                    else if (nul_trunc) state_n = RX_IDLE;
                    else if (is_act) state_n = RX_ACT;
                end
                RX_WORD: state_n = RX_SYNC;
                default: state_n = RX_SYNC;
            endcase
        end
    end

    always_comb begin
        rf_wr = rx_ena & (state == RX_WORD) & ~rf_ff;
        ovf_o = rx_ena & (state == RX_WORD) & rf_ff;
        err_o = rx_ena & (((state == RX_IDLE) & is_ill) |
                          ((state == RX_ACT) & act_err) |
                          ((state == RX_NUL) & (is_ill | nul_trunc)));
    end

endmodule
